// File: rtl/bird_controller.sv
// Frame-rate Flappy Bird controller: bird physics, IDLE/PLAY/DEAD state machine and survival score.
// Optional feature macro BIRD_COLLISION_EN adds the pipe-gap collision check; without it only the floor kills.
module bird_controller #(
    parameter int START_Y      = 240,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = 6,
    parameter int MAX_FALL     = 8,
    parameter int Y_MIN        = 6,
    parameter int Y_MAX        = 474,
`ifdef BIRD_COLLISION_EN
    parameter int GAP_TOP      = 151,
    parameter int GAP_BOT      = 329,
`endif
    parameter int DEAD_FRAMES  = 60,
    parameter int SCORE_FRAMES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flap,
    input  logic       frame_tick,
    output logic [9:0] bird_y,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10} state_t;

    localparam logic [9:0]         START_Y_V  = 10'(START_Y);
    localparam logic signed [7:0]  VEL_FLAP   = 8'(-FLAP_VEL);
    localparam logic signed [7:0]  VEL_GRAV   = 8'(GRAVITY);
    localparam logic signed [7:0]  VEL_MAX    = 8'(MAX_FALL);
    localparam logic signed [10:0] Y_MIN_S    = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S    = 11'(Y_MAX);
    localparam logic [5:0]         DEAD_LAST  = 6'(DEAD_FRAMES);
    localparam logic [5:0]         SCORE_LAST = 6'(SCORE_FRAMES - 1);

    state_t             state_q, state_d;
    logic [9:0]         y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [7:0]         score_q, score_d;
    logic [5:0]         fcnt_q, fcnt_d;
    logic [5:0]         dcnt_q, dcnt_d;
    logic               flap_q, pend_q, pend_d, go_q, go_d;

    logic               flap_edge, flap_take, hit;
    logic signed [7:0]  vel_inc, vel_n;
    logic signed [10:0] y_n, y_c;

    // An edge coincident with a tick is consumed by that tick and not carried forward.
    assign flap_edge = flap & ~flap_q;
    assign flap_take = pend_q | flap_edge;
    assign pend_d    = frame_tick ? 1'b0 : (pend_q | flap_edge);

    always_comb begin
        vel_inc = vel_q + VEL_GRAV;
        vel_n   = flap_take ? VEL_FLAP : ((vel_inc > VEL_MAX) ? VEL_MAX : vel_inc);
        y_n     = $signed({1'b0, y_q}) + $signed({{3{vel_n[7]}}, vel_n});
        if (y_n < Y_MIN_S)       y_c = Y_MIN_S;
        else if (y_n >= Y_MAX_S) y_c = Y_MAX_S;
        else                     y_c = y_n;
    end

`ifdef BIRD_COLLISION_EN
    localparam logic signed [10:0] GAP_TOP_S = 11'(GAP_TOP);
    localparam logic signed [10:0] GAP_BOT_S = 11'(GAP_BOT);
    // Bird occupies rows y-6..y+5; any part outside the open gap is a hit.
    assign hit = (y_c - 11'sd6 < GAP_TOP_S) || (y_c + 11'sd5 > GAP_BOT_S);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        score_d = score_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        go_d    = 1'b0;
        if (frame_tick) begin
            case (state_q)
                IDLE: if (flap_take) begin
                    state_d = PLAY;
                    vel_d   = VEL_FLAP;
                    y_d     = START_Y_V - 10'(FLAP_VEL);
                    fcnt_d  = '0;
                    score_d = '0;
                end
                PLAY: begin
                    if (fcnt_q == SCORE_LAST) begin
                        fcnt_d = '0;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end else begin
                        fcnt_d = fcnt_q + 6'd1;
                    end
                    y_d   = y_c[9:0];
                    vel_d = (y_n < Y_MIN_S) ? 8'sd0 : vel_n;
                    if ((y_n >= Y_MAX_S) || hit) begin
                        state_d = DEAD;
                        go_d    = 1'b1;
                        dcnt_d  = '0;
                    end
                end
                DEAD: begin
                    if (flap_take && (dcnt_q == DEAD_LAST)) begin
                        state_d = IDLE;
                        y_d     = START_Y_V;
                        vel_d   = 8'sd0;
                        score_d = '0;
                        fcnt_d  = '0;
                        dcnt_d  = '0;
                    end else if (dcnt_q != DEAD_LAST) begin
                        dcnt_d = dcnt_q + 6'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= START_Y_V;
            vel_q   <= 8'sd0;
            score_q <= '0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
            flap_q  <= 1'b0;
            pend_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            score_q <= score_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
            flap_q  <= flap;
            pend_q  <= pend_d;
            go_q    <= go_d;
        end
    end

    assign bird_y    = y_q;
    assign state     = state_q;
    assign score     = score_q;
    assign game_over = go_q;

endmodule

// File: tb/tb_bird_controller.sv
// Scoreboard bench for bird_controller: stimulus pushes expected per-tick outputs, monitor pops and compares.
module tb_bird_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flap = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] bird_y;
    logic [1:0] state;
    logic [7:0] score;
    logic       game_over;

    bird_controller dut (
        .clock(clock), .reset(reset), .flap(flap), .frame_tick(frame_tick),
        .bird_y(bird_y), .state(state), .score(score), .game_over(game_over)
    );

    always #5 clock = ~clock;

`ifdef BIRD_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_DEAD = 2;

    typedef struct {
        logic [9:0] y;
        logic [1:0] st;
        logic [7:0] sc;
        logic       go;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   n_tick = 0;
    logic tick_seen = 1'b0;
    logic go_follow = 1'b0;
    logic final_req = 1'b0;
    logic final_done = 1'b0;

    int fall_y[24] = '{234, 229, 225, 222, 220, 219, 219, 220, 222, 225, 229, 234,
                       240, 247, 255, 263, 271, 279, 287, 295, 303, 311, 319, 327};
    int ycyc[13]   = '{234, 229, 225, 222, 220, 219, 219, 220, 222, 225, 229, 234, 240};

    task automatic cmp(input string nm, input int n, input logic [9:0] act, input logic [9:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at tick %0d: got %0d, want %0d", nm, n, act, want);
        end
    endtask

    // Monitor: one expected entry per processed tick, checked on the following falling edge.
    always @(posedge clock) tick_seen <= frame_tick && !reset;

    always @(negedge clock) begin
        exp_t e;
        if (go_follow) cmp("game_over_width", n_tick, {9'd0, game_over}, 10'd0);
        go_follow = 1'b0;
        if (tick_seen) begin
            n_tick++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick at tick %0d: got bird_y %0d, want no tick", n_tick, bird_y);
            end else begin
                e = expq.pop_front();
                cmp("bird_y", n_tick, bird_y, e.y);
                cmp("state", n_tick, {8'd0, state}, {8'd0, e.st});
                cmp("score", n_tick, {2'd0, score}, {2'd0, e.sc});
                cmp("game_over", n_tick, {9'd0, game_over}, {9'd0, e.go});
                go_follow = e.go;
            end
        end
        if (final_req && !final_done) begin
            cmp("queue_drained", n_tick, 10'(expq.size()), 10'd0);
            final_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int y, input int st, input int sc, input logic go);
        exp_t e;
        e.y  = 10'(y);
        e.st = 2'(st);
        e.sc = 8'(sc);
        e.go = go;
        expq.push_back(e);
    endtask

    task automatic pulse_flap();
        flap = 1'b1; step();
        flap = 1'b0; step();
    endtask

    task automatic tick();
        frame_tick = 1'b1; step();
        frame_tick = 1'b0; step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int dead_k, dead_y, mend, k, y;
        dead_k = COLL ? 24 : 43;
        dead_y = COLL ? 327 : 474;

        // Reset with flap toggling; must not leave a pending flap.
        reset = 1'b1; flap = 1'b1; step();
        flap = 1'b0; step();
        reset = 1'b0; step();
        push(240, ST_IDLE, 0, 1'b0); tick();

        // Start and free fall until floor or gap collision.
        pulse_flap();
        for (int i = 1; i <= 24; i++) begin
            push(fall_y[i-1], (i == dead_k) ? ST_DEAD : ST_PLAY, 0, i == dead_k);
            tick();
        end
        for (int i = 25; i <= dead_k; i++) begin
            push((i == dead_k) ? dead_y : 327 + 8 * (i - 24), (i == dead_k) ? ST_DEAD : ST_PLAY, 0, i == dead_k);
            tick();
        end

        // Restart gating: flaps at DEAD ticks 10 and 60 ignored, accepted at 61.
        for (int j = 1; j <= 61; j++) begin
            if (j == 10 || j == 60 || j == 61) pulse_flap();
            push((j == 61) ? 240 : dead_y, (j == 61) ? ST_IDLE : ST_DEAD, 0, 1'b0);
            tick();
        end
        push(240, ST_IDLE, 0, 1'b0); tick();

        // Sustained play (flap every 13 ticks) for 128 PLAY ticks, some ticks back to back.
        pulse_flap();
        push(234, ST_PLAY, 0, 1'b0); tick();
        k = 2;
        while (k <= 129) begin
            if ((k - 1) % 13 == 0) pulse_flap();
            if ((k % 7 == 0) && (k < 129) && (k % 13 != 0)) begin
                push(ycyc[(k - 1) % 13], ST_PLAY, (k - 1) / 64, 1'b0);
                push(ycyc[k % 13], ST_PLAY, k / 64, 1'b0);
                frame_tick = 1'b1; step(); step();
                frame_tick = 1'b0; step();
                k += 2;
            end else begin
                push(ycyc[(k - 1) % 13], ST_PLAY, (k - 1) / 64, 1'b0);
                tick();
                k++;
            end
        end

        // Held flap gives one impulse; edge coincident with a tick is used by that tick.
        flap = 1'b1; step();
        push(228, ST_PLAY, 2, 1'b0); tick();
        push(223, ST_PLAY, 2, 1'b0); tick();
        push(219, ST_PLAY, 2, 1'b0); tick();
        flap = 1'b0; step();
        push(213, ST_PLAY, 2, 1'b0);
        flap = 1'b1; frame_tick = 1'b1; step();
        flap = 1'b0; frame_tick = 1'b0; step();
        push(208, ST_PLAY, 2, 1'b0); tick();

        // Climb every tick: gap-top hit, or ceiling clamp with velocity reset.
        mend = COLL ? 9 : 34;
        for (int m = 1; m <= mend; m++) begin
            pulse_flap();
            y = (m == 34) ? 6 : 208 - 6 * m;
            push(y, (m == mend && COLL) ? ST_DEAD : ST_PLAY, 2, m == mend && COLL);
            tick();
        end
        push(COLL ? 154 : 7, COLL ? ST_DEAD : ST_PLAY, 2, 1'b0); tick();
        push(COLL ? 154 : 9, COLL ? ST_DEAD : ST_PLAY, 2, 1'b0); tick();

        // Reset mid-game beats a simultaneous tick.
        reset = 1'b1; frame_tick = 1'b1; step();
        frame_tick = 1'b0; step();
        reset = 1'b0; step();
        push(240, ST_IDLE, 0, 1'b0); tick();

        repeat (3) step();
        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
